// File: rtl/uart_rx_framer_pkg.sv
// Shared UART definitions: oversampling constants and receiver state encoding.
package uart_rx_framer_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_TICK   = 7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Receive-side write bus from the framer into the RX FIFO.
interface uart_rx_framer_if #(
   parameter int unsigned DBIT = 8
);
   logic [DBIT-1:0] rx_dout;
   logic            rx_done_tick;
   logic            parity_err;
   logic            frame_err;
   logic            break_tick;

   modport master (
      output rx_dout, rx_done_tick, parity_err, frame_err, break_tick
   );

   modport slave (
      input rx_dout, rx_done_tick, parity_err, frame_err, break_tick
   );
endinterface

// File: rtl/uart_rx_framer_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to a chosen level.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic meta;

   // Two-stage capture; both stages preset to the idle level of the input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx_framer.sv
// Oversampling UART receive framer: start/data/parity/stop recovery with
// glitch, parity, framing and break detection, one write strobe per frame.
module uart_rx_framer
   import uart_rx_framer_pkg::*;
#(
   parameter int unsigned DBIT       = 8,
   parameter int unsigned SB_TICK    = 16,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx,
   input  logic              s_tick,
   output logic              busy,
   uart_rx_framer_if.master  fifo
);
   localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
   localparam int unsigned NW = $clog2(DBIT);

   localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   state_t          state;
   logic [SW-1:0]   s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] shreg;
   logic            p;
   logic            brk_hold;
   logic            rx_s;
   logic            brk;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   assign busy = (state != ST_IDLE);

   // Break: all data zero, parity zero (if present) and stop sampled low.
   always_comb begin
      brk = (shreg == '0) && (!PARITY_EN || !p) && !rx_s;
   end

   // Frame FSM with tick/bit counters and registered FIFO-side outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         s                 <= '0;
         n                 <= '0;
         shreg             <= '0;
         p                 <= 1'b0;
         brk_hold          <= 1'b0;
         fifo.rx_dout      <= '0;
         fifo.rx_done_tick <= 1'b0;
         fifo.parity_err   <= 1'b0;
         fifo.frame_err    <= 1'b0;
         fifo.break_tick   <= 1'b0;
      end else begin
         fifo.rx_done_tick <= 1'b0;
         case (state)
            ST_IDLE: begin
               // After a break the line must go high before a new start is accepted;
               // a plain framing error restarts at once if the line is still low.
               if (brk_hold) begin
                  if (rx_s) brk_hold <= 1'b0;
               end else if (!rx_s) begin
                  state <= ST_START;
                  s     <= '0;
               end
            end
            ST_START: begin
               if (s_tick) begin
                  if (s == S_MID) begin
                     if (!rx_s) begin
                        state <= ST_DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     s     <= '0;
                     shreg <= {rx_s, shreg[DBIT-1:1]};
                     if (n == N_LAST) state <= PARITY_EN ? ST_PARITY : ST_STOP;
                     else             n     <= n + 1'b1;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     s     <= '0;
                     p     <= rx_s;
                     state <= ST_STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (s == S_STOP) begin
                     fifo.rx_done_tick <= 1'b1;
                     fifo.rx_dout      <= shreg;
                     fifo.frame_err    <= ~rx_s;
                     fifo.parity_err   <= PARITY_EN && (((^shreg) ^ p) != PARITY_ODD);
                     fifo.break_tick   <= brk;
                     brk_hold          <= brk;
                     state             <= ST_IDLE;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench: one 8N1 receiver and one 8E1 receiver driven with
// bit-level serial frames; results compared against a frame-level model.
module tb_uart_rx_framer;
   localparam int unsigned BITCLK = 64;   // 16 s_ticks at one tick per 4 clk

   typedef struct packed {
      logic [7:0] dout;
      logic       pe;
      logic       fe;
      logic       bk;
   } res_t;

   logic clk = 1'b0;
   logic reset_n;
   logic rx_a, rx_b;
   logic s_tick;
   logic busy_a, busy_b;
   int   checks = 0;
   int   errors = 0;
   res_t qa[$];
   res_t qb[$];

   uart_rx_framer_if #(.DBIT(8)) if_a ();
   uart_rx_framer_if #(.DBIT(8)) if_b ();

   uart_rx_framer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(rx_a), .s_tick(s_tick), .busy(busy_a), .fifo(if_a)
   );

   uart_rx_framer #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx(rx_b), .s_tick(s_tick), .busy(busy_b), .fifo(if_b)
   );

   always #5 clk = ~clk;

   // Free-running 16x baud tick, one clk wide every 4 clk.
   initial begin
      s_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         s_tick <= 1'b1;
         @(posedge clk);
         s_tick <= 1'b0;
      end
   end

   // Record every write strobe seen on either FIFO bus.
   always @(negedge clk) begin
      if (if_a.rx_done_tick) qa.push_back(res_t'({if_a.rx_dout, if_a.parity_err, if_a.frame_err, if_a.break_tick}));
      if (if_b.rx_done_tick) qb.push_back(res_t'({if_b.rx_dout, if_b.parity_err, if_b.frame_err, if_b.break_tick}));
   end

   // Frame-level expectation from the data, parity and stop bits on the line.
   function automatic res_t model(input bit par_en, input logic [7:0] d, input logic p, input logic stop);
      res_t r;
      r.dout = d;
      r.pe   = par_en && (((^d) ^ p) != 1'b0);
      r.fe   = !stop;
      r.bk   = (d == 8'h00) && (!par_en || !p) && !stop;
      return r;
   endfunction

   task automatic drive(input bit b, input logic v, input int unsigned nclk);
      if (b) rx_b = v;
      else   rx_a = v;
      repeat (nclk) @(negedge clk);
   endtask

   // Line B carries a parity bit; a low stop bit is shortened so the line is
   // clearly high again before any restarted start-bit check.
   task automatic send(input bit b, input logic [7:0] d, input logic p, input logic stop);
      drive(b, 1'b0, BITCLK);
      for (int i = 0; i < 8; i++) drive(b, d[i], BITCLK);
      if (b) drive(b, p, BITCLK);
      if (stop) drive(b, 1'b1, BITCLK);
      else begin
         drive(b, 1'b0, 40);
         drive(b, 1'b1, 24);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      rx_a = 1'b1;
      rx_b = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({if_a.rx_dout, if_a.rx_done_tick, if_a.parity_err, if_a.frame_err, if_a.break_tick, busy_a} !== 13'd0)
         $display("FAIL reset_a got dout=%h done=%b pe=%b fe=%b bk=%b busy=%b want all 0",
                  if_a.rx_dout, if_a.rx_done_tick, if_a.parity_err, if_a.frame_err, if_a.break_tick, busy_a);
      checks++;
      if ({if_b.rx_dout, if_b.rx_done_tick, if_b.parity_err, if_b.frame_err, if_b.break_tick, busy_b} !== 13'd0)
         $display("FAIL reset_b got dout=%h done=%b pe=%b fe=%b bk=%b busy=%b want all 0",
                  if_b.rx_dout, if_b.rx_done_tick, if_b.parity_err, if_b.frame_err, if_b.break_tick, busy_b);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (qa.size() + qb.size() != 0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got ticks=%0d busy=%b%b want ticks=0 busy=00", qa.size() + qb.size(), busy_a, busy_b);
      end
      if ({if_a.rx_dout, busy_a} !== 9'd0 || {if_b.rx_dout, busy_b} !== 9'd0) errors++;
   endtask

   task automatic test_single;
      res_t want;
      qa.delete();
      send(0, 8'hA5, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      want = model(0, 8'hA5, 1'b0, 1'b1);
      checks++;
      if (qa.size() != 1) begin
         errors++;
         $display("FAIL single_count got %0d want 1", qa.size());
      end else begin
         checks++;
         if (qa[0] !== want) begin
            errors++;
            $display("FAIL single_frame got %h want %h", qa[0], want);
         end
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL single_busy got %b want 0", busy_a);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (if_a.rx_dout !== 8'hA5) begin
         errors++;
         $display("FAIL single_hold got %h want a5", if_a.rx_dout);
      end
   endtask

   task automatic test_glitch;
      res_t want;
      qa.delete();
      drive(0, 1'b0, 20);
      drive(0, 1'b1, 80);
      checks++;
      if (qa.size() != 0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL glitch got ticks=%0d busy=%b want ticks=0 busy=0", qa.size(), busy_a);
      end
      send(0, 8'h3C, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      want = model(0, 8'h3C, 1'b0, 1'b1);
      checks++;
      if (qa.size() != 1 || qa[0] !== want) begin
         errors++;
         $display("FAIL glitch_next got n=%0d frame=%h want n=1 frame=%h", qa.size(), (qa.size() > 0) ? qa[0] : res_t'('0), want);
      end
   endtask

   task automatic test_parity;
      logic [7:0] d;
      logic       p, stop;
      res_t       want;
      for (int i = 0; i < 8; i++) begin
         if (i < 2) begin
            d = 8'h07; p = (i == 0); stop = 1'b1;
         end else begin
            d = 8'($urandom); p = 1'($urandom); stop = ($urandom_range(0, 3) != 0);
         end
         qb.delete();
         send(1, d, p, stop);
         repeat (4) @(negedge clk);
         want = model(1, d, p, stop);
         checks++;
         if (qb.size() != 1 || qb[0] !== want) begin
            errors++;
            $display("FAIL parity[%0d] got n=%0d frame=%h want n=1 frame=%h (d=%h p=%b stop=%b)",
                     i, qb.size(), (qb.size() > 0) ? qb[0] : res_t'('0), want, d, p, stop);
         end
      end
   endtask

   task automatic test_framing;
      res_t want;
      qa.delete();
      send(0, 8'h55, 1'b0, 1'b0);
      drive(0, 1'b1, BITCLK);
      want = model(0, 8'h55, 1'b0, 1'b0);
      checks++;
      if (qa.size() != 1 || qa[0] !== want) begin
         errors++;
         $display("FAIL frame_err got n=%0d frame=%h want n=1 frame=%h", qa.size(), (qa.size() > 0) ? qa[0] : res_t'('0), want);
      end
      qa.delete();
      drive(0, 1'b0, 12 * BITCLK);
      want = model(0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (qa.size() != 1 || qa[0] !== want || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL break got n=%0d frame=%h busy=%b want n=1 frame=%h busy=0",
                  qa.size(), (qa.size() > 0) ? qa[0] : res_t'('0), busy_a, want);
      end
      drive(0, 1'b1, 2 * BITCLK);
      checks++;
      if (qa.size() != 1) begin
         errors++;
         $display("FAIL break_rearm got ticks=%0d want 1", qa.size());
      end
      send(0, 8'h96, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      want = model(0, 8'h96, 1'b0, 1'b1);
      checks++;
      if (qa.size() != 2 || qa[qa.size()-1] !== want) begin
         errors++;
         $display("FAIL break_next got n=%0d want n=2 frame=%h", qa.size(), want);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] d[8];
      res_t       want;
      for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
      d[5] = 8'h00; d[6] = 8'hFF; d[7] = 8'h81;
      qa.delete();
      for (int i = 0; i < 8; i++) send(0, d[i], 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (qa.size() != 8) begin
         errors++;
         $display("FAIL b2b_count got %0d want 8", qa.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            want = model(0, d[i], 1'b0, 1'b1);
            checks++;
            if (qa[i] !== want) begin
               errors++;
               $display("FAIL b2b[%0d] got %h want %h", i, qa[i], want);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      res_t       want;
      d = 8'hC3;
      qa.delete();
      drive(0, 1'b0, BITCLK);
      for (int i = 0; i < 3; i++) drive(0, d[i], BITCLK);
      drive(0, d[3], 32);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({if_a.rx_dout, if_a.rx_done_tick, if_a.parity_err, if_a.frame_err, if_a.break_tick, busy_a} !== 13'd0) begin
         errors++;
         $display("FAIL reset_mid got dout=%h done=%b busy=%b want 0 0 0", if_a.rx_dout, if_a.rx_done_tick, busy_a);
      end
      rx_a = 1'b1;
      repeat (20) @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (qa.size() != 0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet got ticks=%0d busy=%b want 0 0", qa.size(), busy_a);
      end
      send(0, 8'h5A, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      want = model(0, 8'h5A, 1'b0, 1'b1);
      checks++;
      if (qa.size() != 1 || qa[0] !== want) begin
         errors++;
         $display("FAIL reset_mid_next got n=%0d frame=%h want n=1 frame=%h", qa.size(), (qa.size() > 0) ? qa[0] : res_t'('0), want);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_single;
      test_glitch;
      test_parity;
      test_framing;
      test_back_to_back;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Oversampling UART receive framer. Takes the raw asynchronous `rx` line and the 16x baud tick from the baud timer.
- Recovers start / data / optional parity / stop bits and delivers each received byte to the receive FIFO as a one-clock write strobe with data.
- Adds glitch rejection, parity checking, framing-error detection and break detection, all reported coincident with the byte strobe.

Parameters:
- DBIT, 8, number of data bits per frame (5..9), LSB first.
- SB_TICK, 16, stop-bit length in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- s_tick  input  1  one-clk pulse at 16x baud rate.
- rx_dout  output  DBIT  received data word.
- rx_done_tick  output  1  one-clk pulse: frame complete, rx_dout and flags valid (drives FIFO wr_en).
- parity_err  output  1  valid with rx_done_tick: parity mismatch.
- frame_err  output  1  valid with rx_done_tick: stop bit sampled low.
- break_tick  output  1  valid with rx_done_tick: all data bits, parity bit (if present) and stop bit sampled 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset
  - clk single clock domain; reset_n asynchronous assert, active low; release is synchronous to clk (external reset synchroniser).
  - During reset: state = IDLE, tick counter s = 0, bit counter n = 0, shift register = 0.
  - During reset: rx_dout = 0, all flags and ticks = 0.
  - During reset: synchroniser flops preset to 1 (idle line), so releasing reset never produces a false start.
- Synchroniser: rx passes through 2 flops → rx_s. Total input latency is 2 clk, and all sampling uses rx_s.
- Counters: s (4 bits, or wide enough for SB_TICK-1) and n advance only on clocks where s_tick = 1.
- IDLE
  - On rx_s = 0: go to START, s = 0.
  - s_tick is not required to detect the edge.
- START (mid-bit check)
  - On s_tick with s = 7: if rx_s = 0, go to DATA with s = 0, n = 0.
  - If rx_s = 1 at that point: glitch; return to IDLE with no output.
  - Otherwise on s_tick: s = s + 1.
- DATA
  - On s_tick with s = 15: shift rx_s into the MSB of a DBIT shift register (right shift, LSB first on the line), s = 0.
  - If n = DBIT-1: go to PARITY when PARITY_EN, else STOP. Otherwise n = n + 1.
- PARITY
  - On s_tick with s = 15: capture parity bit p, s = 0, go to STOP.
  - parity_err = (XOR(data) ^ p) != PARITY_ODD. p is also used for the break check.
- STOP
  - On s_tick with s = SB_TICK-1: assert rx_done_tick for exactly one clk, go to IDLE.
  - frame_err = ~rx_s sampled at that tick.
  - break_tick = (data == 0) && (no parity or p == 0) && rx_s == 0.
- Outputs registered: rx_dout and all flags update in the same clk that rx_done_tick rises.
  - They hold until the next rx_done_tick.
  - parity_err is forced to 0 when PARITY_EN = 0.
- rx_done_tick is asserted even when errors are flagged. The consumer decides whether to discard.
- Back-to-back frames
  - IDLE is re-entered in the clk after the final stop sample, so a start bit immediately following is detected with no lost tick.
  - On frame_err, if rx_s is still 0 in IDLE, a new START is entered immediately. Break is re-armed only after the line returns high.
- No back-pressure: the block does not observe FIFO full; overflow handling belongs to the FIFO.
- reset_n low mid-frame: immediate return to reset values, no rx_done_tick, partial byte discarded.
- Initial s_tick phase relative to the start edge is arbitrary. Sampling error is at most 1 tick (1/16 bit).

Decomposition:
- Shared package/include uart_pkg holds:
  - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP (3 bits);
  - OVERSAMPLE = 16 and MID_TICK = 7, also used by the transmitter.
- One sub-module: uart_sync2, a 2-flop synchroniser with parameterised reset value (1 here), reusable for other async inputs.
- The FSM, counters and checks stay in uart_rx_framer.

Test Plan:
- Common setup: s_tick every 4 clk, default parameters.
- Single frame: send 0xA5 8N1 → exactly one rx_done_tick; rx_dout = 8'hA5; parity_err = frame_err = break_tick = 0; busy returns low 1 clk later.
- Glitch: rx low for 5 s_ticks then high → no rx_done_tick, state back to IDLE. A following frame 0x3C is then received correctly.
- Parity: PARITY_EN = 1, PARITY_ODD = 0.
  - Send 0x07 with p = 1 → parity_err = 0.
  - Send 0x07 with p = 0 → parity_err = 1, rx_dout = 8'h07.
- Framing/break:
  - Send 0x55 with stop bit 0 → frame_err = 1, break_tick = 0.
  - Hold rx low for 12 bit times → rx_done_tick with rx_dout = 0, frame_err = 1, break_tick = 1, and no further tick until rx returns high and a new start bit arrives.
- Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap → three ticks, correct data in order, no errors.
- Reset mid-frame: assert reset_n low during bit 3 of 0xC3 → outputs 0 immediately, no rx_done_tick. After release, a clean frame 0x5A is received correctly.
